// File: rtl/skid_pipe_pkg.sv
// Shared definitions for the skid_pipe pipeline: mode constants and the
// occupancy counter width.
package skid_pipe_pkg;

    localparam int RIGID_OFF    = 32'sd0;
    localparam int RIGID_ON     = 32'sd1;
    localparam int REG_HOLD_OFF = 32'sd0;
    localparam int REG_HOLD_ON  = 32'sd1;

    // Wide enough to count every stage plus the optional skid word.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 32'sd2);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/data pipeline stage; hold is chained from the downstream stage and
// a stage that is empty (collapsing mode) never propagates backpressure.
module pipe_stage
    import skid_pipe_pkg::*;
#(
    parameter int DW    = 8,
    parameter int RIGID = RIGID_OFF
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    input  logic          up_valid,
    input  logic [DW-1:0] up_data,
    input  logic          dn_hold,
    output logic          hold,
    output logic          valid,
    output logic          valid_nxt,
    output logic [DW-1:0] data
);

    logic          valid_r;
    logic [DW-1:0] data_r;
    logic          rigid_s;

    assign rigid_s = (RIGID != RIGID_OFF);

    // Backpressure seen by the upstream stage.
    always_comb begin
        hold = dn_hold & (valid_r | rigid_s);
    end

    // Next valid flag; reset dominates flush, flush dominates normal flow.
    always_comb begin
        valid_nxt = 1'b0;
        if (!resetn) begin
            valid_nxt = 1'b0;
        end else if (flush) begin
            valid_nxt = 1'b0;
        end else if (!hold) begin
            valid_nxt = up_valid;
        end else begin
            valid_nxt = valid_r;
        end
    end

    // Valid flag register.
    always_ff @(posedge clk) begin
        valid_r <= valid_nxt;
    end

    // Data register, loaded only with a valid incoming word; never reset.
    always_ff @(posedge clk) begin
        if (up_valid && !hold) begin
            data_r <= up_data;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;

endmodule

// File: rtl/skid_pipe.sv
// DEPTH-stage valid/hold pipeline with optional input skid register so that
// di_hold can come straight from a flop, plus a registered occupancy count.
module skid_pipe
    import skid_pipe_pkg::*;
#(
    parameter  int DW       = 8,
    parameter  int DEPTH    = 2,
    parameter  int RIGID    = RIGID_OFF,
    parameter  int REG_HOLD = REG_HOLD_OFF,
    localparam int OCC_W    = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             di_valid,
    input  logic [DW-1:0]    di,
    output logic             di_hold,
    output logic             q_valid,
    output logic [DW-1:0]    q,
    input  logic             q_hold,
    output logic [OCC_W-1:0] occupancy
);

    logic             skid_valid_r;
    logic             skid_valid_nxt_s;
    logic [DW-1:0]    skid_r;
    logic             hold0_s;
    logic             in_valid_s;
    logic [DW-1:0]    in_data_s;
    logic [DEPTH-1:0] valid_nxt_vec_s;
    logic [OCC_W-1:0] occ_nxt_s;
    logic [OCC_W-1:0] occ_r;

    // Stage 0 drains the skid word before taking new input.
    always_comb begin
        in_valid_s = di_valid;
        in_data_s  = di;
        if (skid_valid_r) begin
            in_valid_s = 1'b1;
            in_data_s  = skid_r;
        end else begin
            in_valid_s = di_valid;
            in_data_s  = di;
        end
    end

    // Skid fills on a word accepted while stage 0 is held and empties as soon as stage 0 moves.
    always_comb begin
        skid_valid_nxt_s = 1'b0;
        if (!resetn) begin
            skid_valid_nxt_s = 1'b0;
        end else if (flush) begin
            skid_valid_nxt_s = 1'b0;
        end else if (skid_valid_r) begin
            skid_valid_nxt_s = hold0_s;
        end else if (REG_HOLD != REG_HOLD_OFF) begin
            skid_valid_nxt_s = di_valid & hold0_s;
        end else begin
            skid_valid_nxt_s = 1'b0;
        end
    end

    // Skid valid flag register.
    always_ff @(posedge clk) begin
        skid_valid_r <= skid_valid_nxt_s;
    end

    // Skid data capture; never reset.
    always_ff @(posedge clk) begin
        if (!skid_valid_r && di_valid && hold0_s) begin
            skid_r <= di;
        end
    end

    // Upstream backpressure source depends on the skid mode.
    always_comb begin
        if (REG_HOLD != REG_HOLD_OFF) begin
            di_hold = skid_valid_r;
        end else begin
            di_hold = hold0_s;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : stage_g
        logic          up_valid_s;
        logic [DW-1:0] up_data_s;
        logic          dn_hold_s;
        logic          hold_s;
        logic          valid_s;
        logic          valid_nxt_s;
        logic [DW-1:0] data_s;

        if (k == 0) begin : head_g
            assign up_valid_s = in_valid_s;
            assign up_data_s  = in_data_s;
        end else begin : link_g
            assign up_valid_s = stage_g[k-1].valid_s;
            assign up_data_s  = stage_g[k-1].data_s;
        end

        if (k == DEPTH - 1) begin : tail_g
            assign dn_hold_s = q_hold;
        end else begin : chain_g
            assign dn_hold_s = stage_g[k+1].hold_s;
        end

        pipe_stage #(
            .DW    (DW),
            .RIGID (RIGID)
        ) u_stage (
            .clk       (clk),
            .resetn    (resetn),
            .flush     (flush),
            .up_valid  (up_valid_s),
            .up_data   (up_data_s),
            .dn_hold   (dn_hold_s),
            .hold      (hold_s),
            .valid     (valid_s),
            .valid_nxt (valid_nxt_s),
            .data      (data_s)
        );

        assign valid_nxt_vec_s[k] = valid_nxt_s;
    end

    assign hold0_s = stage_g[0].hold_s;
    assign q_valid = stage_g[DEPTH-1].valid_s;
    assign q       = stage_g[DEPTH-1].data_s;

    // Popcount of next-cycle valid flags so the registered count tracks the flags exactly.
    always_comb begin
        occ_nxt_s = {OCC_W{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            occ_nxt_s = occ_nxt_s + OCC_W'(valid_nxt_vec_s[k]);
        end
        occ_nxt_s = occ_nxt_s + OCC_W'(skid_valid_nxt_s);
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        occ_r <= occ_nxt_s;
    end

    assign occupancy = occ_r;

endmodule

// File: tb/tb_skid_pipe.sv
// Self-checking bench: four skid_pipe configurations share one stimulus stream,
// each compared against a word-queue reference model.
module tb_skid_pipe;

    localparam int NI = 4;
    localparam int DEP [NI] = '{3, 3, 3, 1};
    localparam int RIG [NI] = '{0, 0, 1, 0};
    localparam int RH  [NI] = '{0, 1, 0, 1};

    logic       clk = 1'b0;
    logic       resetn, flush, di_valid, q_hold;
    logic [7:0] di;
    logic       qv [NI];
    logic [7:0] qd [NI];
    logic       dh [NI];
    logic [7:0] occ_a [NI];
    logic [2:0] oc0, oc1, oc2;
    logic [1:0] oc3;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [7:0] mq [NI][$];
    int         mc [NI][$];

    always #5 clk = ~clk;

    skid_pipe #(.DW(8), .DEPTH(3), .RIGID(0), .REG_HOLD(0)) u0 (
        .clk(clk), .resetn(resetn), .flush(flush), .di_valid(di_valid), .di(di),
        .di_hold(dh[0]), .q_valid(qv[0]), .q(qd[0]), .q_hold(q_hold), .occupancy(oc0));
    skid_pipe #(.DW(8), .DEPTH(3), .RIGID(0), .REG_HOLD(1)) u1 (
        .clk(clk), .resetn(resetn), .flush(flush), .di_valid(di_valid), .di(di),
        .di_hold(dh[1]), .q_valid(qv[1]), .q(qd[1]), .q_hold(q_hold), .occupancy(oc1));
    skid_pipe #(.DW(8), .DEPTH(3), .RIGID(1), .REG_HOLD(0)) u2 (
        .clk(clk), .resetn(resetn), .flush(flush), .di_valid(di_valid), .di(di),
        .di_hold(dh[2]), .q_valid(qv[2]), .q(qd[2]), .q_hold(q_hold), .occupancy(oc2));
    skid_pipe #(.DW(8), .DEPTH(1), .RIGID(0), .REG_HOLD(1)) u3 (
        .clk(clk), .resetn(resetn), .flush(flush), .di_valid(di_valid), .di(di),
        .di_hold(dh[3]), .q_valid(qv[3]), .q(qd[3]), .q_hold(q_hold), .occupancy(oc3));

    assign occ_a[0] = {5'd0, oc0};
    assign occ_a[1] = {5'd0, oc1};
    assign occ_a[2] = {5'd0, oc2};
    assign occ_a[3] = {6'd0, oc3};

    // One clock cycle: drive inputs, check outputs against the word queues, advance the model.
    task automatic step(input logic v, input logic [7:0] d, input logic h,
                        input logic f, input logic r, input bit lat);
        logic exp_hold;
        di_valid = v; di = d; q_hold = h; flush = f; resetn = r;
        #2;
        for (int k = 0; k < NI; k++) begin
            if (!r) begin
                mq[k].delete(); mc[k].delete();
            end else begin
                if (RH[k] != 0) exp_hold = (mq[k].size() == DEP[k] + 1);
                else            exp_hold = h && ((RIG[k] != 0) || (mq[k].size() == DEP[k]));
                checks++;
                if (dh[k] !== exp_hold) begin
                    errors++;
                    $display("FAIL di_hold dut%0d cyc %0d got %0b want %0b", k, cyc, dh[k], exp_hold);
                end
                if (qv[k] === 1'b1) begin
                    checks++;
                    if (mq[k].size() == 0) begin
                        errors++;
                        $display("FAIL spurious_q dut%0d cyc %0d got %02h want no word", k, cyc, qd[k]);
                    end else begin
                        if (qd[k] !== mq[k][0]) begin
                            errors++;
                            $display("FAIL order dut%0d cyc %0d got %02h want %02h", k, cyc, qd[k], mq[k][0]);
                        end
                        if (lat) begin
                            checks++;
                            if (cyc - mc[k][0] != DEP[k]) begin
                                errors++;
                                $display("FAIL latency dut%0d cyc %0d got %0d want %0d", k, cyc, cyc - mc[k][0], DEP[k]);
                            end
                        end
                        if (!h) begin
                            void'(mq[k].pop_front());
                            void'(mc[k].pop_front());
                        end
                    end
                end
                if (f) begin
                    mq[k].delete(); mc[k].delete();
                end else if (v && dh[k] === 1'b0) begin
                    mq[k].push_back(d); mc[k].push_back(cyc);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (occ_a[k] !== 8'(mq[k].size())) begin
                errors++;
                $display("FAIL occupancy dut%0d cyc %0d got %0d want %0d", k, cyc, occ_a[k], mq[k].size());
            end
        end
    endtask

    task automatic drain(input int n, input bit lat);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, lat);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (mq[k].size() != 0) begin
                errors++;
                $display("FAIL lost_words dut%0d got %0d left want 0", k, mq[k].size());
            end
        end
    endtask

    task automatic test_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (qv[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_q_valid dut%0d got %0b want 0", k, qv[k]);
            end
            if (RH[k] != 0) begin
                checks++;
                if (dh[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_di_hold dut%0d got %0b want 0", k, dh[k]);
                end
            end
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_stream();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b1, 1'b1);
            if (i >= 2) begin
                checks++;
                if (occ_a[0] !== 8'd3) begin
                    errors++;
                    $display("FAIL stream_occ cyc %0d got %0d want 3", cyc, occ_a[0]);
                end
            end
        end
        drain(8, 1'b1);
    endtask

    task automatic test_hold();
        int exp_occ [NI] = '{3, 4, 0, 2};
        for (int i = 0; i < 10; i++) step(1'b1, 8'(i + 1), 1'b1, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (occ_a[k] !== 8'(exp_occ[k])) begin
                errors++;
                $display("FAIL hold_fill_occ dut%0d got %0d want %0d", k, occ_a[k], exp_occ[k]);
            end
        end
        drain(8, 1'b0);
    endtask

    task automatic test_bubbles();
        int s2;
        for (int i = 0; i < 6; i++) step(1'(i % 2 == 0), 8'(8'h20 + i), 1'b0, 1'b0, 1'b1, 1'b0);
        s2 = mq[2].size();
        for (int i = 0; i < 4; i++) step(1'(i % 2 == 0), 8'(8'h30 + i), 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (occ_a[0] !== 8'd3) begin
            errors++;
            $display("FAIL bubble_squeeze got %0d want 3", occ_a[0]);
        end
        checks++;
        if (occ_a[2] !== 8'(s2)) begin
            errors++;
            $display("FAIL rigid_bubbles got %0d want %0d", occ_a[2], s2);
        end
        drain(8, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (qv[0] !== 1'b1) begin
            errors++;
            $display("FAIL flush_presented got %0b want 1", qv[0]);
        end
        step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (qv[k] !== 1'b0 || occ_a[k] !== 8'd0) begin
                errors++;
                $display("FAIL flush_clear dut%0d got q_valid %0b occ %0d want 0 0", k, qv[k], occ_a[k]);
            end
        end
        drain(4, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h50 + i), 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h5F, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (qv[k] !== 1'b0 || occ_a[k] !== 8'd0) begin
                errors++;
                $display("FAIL midreset_clear dut%0d got q_valid %0b occ %0d want 0 0", k, qv[k], occ_a[k]);
            end
            if (RH[k] != 0) begin
                checks++;
                if (dh[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL midreset_di_hold dut%0d got %0b want 0", k, dh[k]);
                end
            end
        end
        drain(4, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 49) == 0), 1'b1, 1'b0);
        end
        drain(8, 1'b0);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_bubbles();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
